// File: rtl/fetch_pkg.sv
// Shared types for the f2 fetch-request stage: head FSM states, queue entry layout
// and address geometry.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int CLC_WIDTH   = 26;
  localparam int LINE_OFF    = XLEN - CLC_WIDTH;
  localparam int FETCH_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_MMIO_E = 3'd2,
    ST_MMIO_O = 3'd3,
    ST_POP    = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] even_addr;
    logic [XLEN-1:0] odd_addr;
    logic            even_v;
    logic            odd_v;
    logic            pcd;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_req_fifo.sv
// Small in-order request queue. Pointers wrap naturally because DEPTH is a power of 2;
// clear empties the queue on the next edge and outranks push/pop.
module fetch_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/f2_fetch_req.sv
// f2 fetch-request stage: queues translated line pairs from f1 and issues them to the
// even/odd I-cache banks or the MMIO port. Every req output is a level held until ack.
module f2_fetch_req
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            hit,
  input  logic            pcd,
  input  logic            exceptions,
  input  logic            addr_even_valid,
  input  logic            addr_odd_valid,
  input  logic [XLEN-1:0] addr_even,
  input  logic [XLEN-1:0] addr_odd,
  output logic            ic_even_req,
  output logic [XLEN-1:0] ic_even_addr,
  input  logic            ic_even_ack,
  output logic            ic_odd_req,
  output logic [XLEN-1:0] ic_odd_addr,
  input  logic            ic_odd_ack,
  output logic            mmio_req,
  output logic [XLEN-1:0] mmio_addr,
  input  logic            mmio_ack,
  output logic            tlb_miss,
  output logic            fault,
  output logic            busy,
  output fetch_state_e    state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state, state_nxt;
  fetch_entry_t  head, push_entry;
  logic [CW-1:0] q_count;
  logic          q_full, q_empty;
  logic          accept, push, pop;
  logic          even_done, odd_done;
  logic          even_pend, odd_pend;

  // Handshake: f1 transfers when in_valid && in_ready; each downstream req is held,
  // address stable, until the cycle its ack is sampled high; flush cancels everything.
  assign accept     = in_valid && in_ready && !flush;
  assign push       = accept && !exceptions && hit && (addr_even_valid || addr_odd_valid);
  assign pop        = (state == ST_POP) && !flush;
  assign push_entry = '{even_addr: addr_even, odd_addr: addr_odd,
                        even_v: addr_even_valid, odd_v: addr_odd_valid, pcd: pcd};

  fetch_req_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign in_ready  = !q_full;
  assign busy      = (q_count != '0) || (state != ST_IDLE);
  assign state_dbg = state;
  assign even_pend = head.even_v && !even_done;
  assign odd_pend  = head.odd_v && !odd_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          if (!head.pcd)       state_nxt = ST_ISSUE;
          else if (head.even_v) state_nxt = ST_MMIO_E;
          else                 state_nxt = ST_MMIO_O;
        end
      end
      ST_ISSUE: begin
        if ((!even_pend || ic_even_ack) && (!odd_pend || ic_odd_ack)) state_nxt = ST_POP;
      end
      ST_MMIO_E: if (mmio_ack) state_nxt = head.odd_v ? ST_MMIO_O : ST_POP;
      ST_MMIO_O: if (mmio_ack) state_nxt = ST_POP;
      ST_POP:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_comb begin
    ic_even_req  = 1'b0;
    ic_even_addr = '0;
    ic_odd_req   = 1'b0;
    ic_odd_addr  = '0;
    mmio_req     = 1'b0;
    mmio_addr    = '0;
    unique case (state)
      ST_ISSUE: begin
        ic_even_req  = even_pend;
        ic_even_addr = even_pend ? head.even_addr : '0;
        ic_odd_req   = odd_pend;
        ic_odd_addr  = odd_pend ? head.odd_addr : '0;
      end
      ST_MMIO_E: begin
        mmio_req  = 1'b1;
        mmio_addr = head.even_addr;
      end
      ST_MMIO_O: begin
        mmio_req  = 1'b1;
        mmio_addr = head.odd_addr;
      end
      default: ;
    endcase
  end

  // Per-bank completion for the current cached pair; cleared when the entry retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      even_done <= 1'b0;
      odd_done  <= 1'b0;
    end else if (flush || state != ST_ISSUE) begin
      even_done <= 1'b0;
      odd_done  <= 1'b0;
    end else begin
      if (ic_even_req && ic_even_ack) even_done <= 1'b1;
      if (ic_odd_req && ic_odd_ack)   odd_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tlb_miss <= 1'b0;
      fault    <= 1'b0;
    end else begin
      tlb_miss <= accept && !exceptions && !hit;
      fault    <= accept && exceptions;
    end
  end

endmodule

// File: tb/tb_f2_fetch_req.sv
// Bench for f2_fetch_req: directed scenarios plus randomized traffic against a
// transaction-level model of which addresses each port must carry, in order.
module tb_f2_fetch_req;
  import fetch_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0, in_valid = 1'b0, hit = 1'b0, pcd = 1'b0, exceptions = 1'b0;
  logic            addr_even_valid = 1'b0, addr_odd_valid = 1'b0;
  logic [XLEN-1:0] addr_even = '0, addr_odd = '0;
  logic            ic_even_ack = 1'b0, ic_odd_ack = 1'b0, mmio_ack = 1'b0;
  logic            in_ready, ic_even_req, ic_odd_req, mmio_req, tlb_miss, fault, busy;
  logic [XLEN-1:0] ic_even_addr, ic_odd_addr, mmio_addr;
  fetch_state_e    state_dbg;

  int checks = 0;
  int errors = 0;
  bit auto_ack = 1'b0;

  logic [XLEN-1:0] exp_even_q[$];
  logic [XLEN-1:0] exp_odd_q[$];
  logic [XLEN-1:0] exp_mmio_q[$];

  f2_fetch_req dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .hit(hit), .pcd(pcd), .exceptions(exceptions),
    .addr_even_valid(addr_even_valid), .addr_odd_valid(addr_odd_valid),
    .addr_even(addr_even), .addr_odd(addr_odd),
    .ic_even_req(ic_even_req), .ic_even_addr(ic_even_addr), .ic_even_ack(ic_even_ack),
    .ic_odd_req(ic_odd_req), .ic_odd_addr(ic_odd_addr), .ic_odd_ack(ic_odd_ack),
    .mmio_req(mmio_req), .mmio_addr(mmio_addr), .mmio_ack(mmio_ack),
    .tlb_miss(tlb_miss), .fault(fault), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_st(input string name, input fetch_state_e act, input fetch_state_e exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s at %0t", name, act.name(), exp.name(), $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [XLEN-1:0] addr);
    checks++;
    errors++;
    $display("FAIL %s: got request addr %h expected no request at %0t", name, addr, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic h, input logic p, input logic e,
                          input logic ev, input logic ov,
                          input logic [XLEN-1:0] ea, input logic [XLEN-1:0] oa);
    in_valid = v; hit = h; pcd = p; exceptions = e;
    addr_even_valid = ev; addr_odd_valid = ov; addr_even = ea; addr_odd = oa;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || exp_even_q.size() != 0 || exp_odd_q.size() != 0 ||
            exp_mmio_q.size() != 0) && n < limit) begin
      step();
      n++;
    end
    check_bit("drain_busy", busy, 1'b0);
    check("drain_even_left", 32'(exp_even_q.size()), '0);
    check("drain_odd_left", 32'(exp_odd_q.size()), '0);
    check("drain_mmio_left", 32'(exp_mmio_q.size()), '0);
  endtask

  always @(posedge clk) begin
    #1;
    if (auto_ack) begin
      ic_even_ack = ($urandom_range(0, 2) == 0);
      ic_odd_ack  = ($urandom_range(0, 2) == 0);
      mmio_ack    = ($urandom_range(0, 2) == 0);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  // Inputs change only just after posedge, so at negedge every value equals what the
  // coming posedge samples: handshakes and f1 accepts are judged here.
  logic            exp_miss_next = 1'b0, exp_fault_next = 1'b0;
  logic            pend_e = 1'b0, pend_o = 1'b0, pend_m = 1'b0;
  logic [XLEN-1:0] pa_e = '0, pa_o = '0, pa_m = '0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_even_q.delete(); exp_odd_q.delete(); exp_mmio_q.delete();
      exp_miss_next = 1'b0; exp_fault_next = 1'b0;
      pend_e = 1'b0; pend_o = 1'b0; pend_m = 1'b0;
    end else begin
      check_bit("tlb_miss_pulse", tlb_miss, exp_miss_next);
      check_bit("fault_pulse", fault, exp_fault_next);
      if (pend_e) begin
        check_bit("even_req_held", ic_even_req, 1'b1);
        check("even_addr_stable", ic_even_addr, pa_e);
      end
      if (pend_o) begin
        check_bit("odd_req_held", ic_odd_req, 1'b1);
        check("odd_addr_stable", ic_odd_addr, pa_o);
      end
      if (pend_m) begin
        check_bit("mmio_req_held", mmio_req, 1'b1);
        check("mmio_addr_stable", mmio_addr, pa_m);
      end
      exp_miss_next = 1'b0;
      exp_fault_next = 1'b0;
      if (flush) begin
        exp_even_q.delete(); exp_odd_q.delete(); exp_mmio_q.delete();
        pend_e = 1'b0; pend_o = 1'b0; pend_m = 1'b0;
      end else begin
        if (ic_even_req && ic_even_ack) begin
          if (exp_even_q.size() == 0) unexpected("even_unexpected", ic_even_addr);
          else check("even_addr", ic_even_addr, exp_even_q.pop_front());
        end
        if (ic_odd_req && ic_odd_ack) begin
          if (exp_odd_q.size() == 0) unexpected("odd_unexpected", ic_odd_addr);
          else check("odd_addr", ic_odd_addr, exp_odd_q.pop_front());
        end
        if (mmio_req && mmio_ack) begin
          if (exp_mmio_q.size() == 0) unexpected("mmio_unexpected", mmio_addr);
          else check("mmio_addr", mmio_addr, exp_mmio_q.pop_front());
        end
        pend_e = ic_even_req && !ic_even_ack; pa_e = ic_even_addr;
        pend_o = ic_odd_req && !ic_odd_ack;   pa_o = ic_odd_addr;
        pend_m = mmio_req && !mmio_ack;       pa_m = mmio_addr;
        // Reference model: what an accepted translation must turn into.
        if (in_valid && in_ready) begin
          if (exceptions)    exp_fault_next = 1'b1;
          else if (!hit)     exp_miss_next = 1'b1;
          else if (pcd) begin
            if (addr_even_valid) exp_mmio_q.push_back(addr_even);
            if (addr_odd_valid)  exp_mmio_q.push_back(addr_odd);
          end else begin
            if (addr_even_valid) exp_even_q.push_back(addr_even);
            if (addr_odd_valid)  exp_odd_q.push_back(addr_odd);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #1 rst = 1'b0;
    #2;
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_even_req", ic_even_req, 1'b0);
    check_bit("rst_odd_req", ic_odd_req, 1'b0);
    check_bit("rst_mmio_req", mmio_req, 1'b0);
    check("rst_mmio_addr", mmio_addr, '0);
    check_bit("rst_pulses", tlb_miss | fault, 1'b0);
    check_st("rst_state", state_dbg, ST_IDLE);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step();

    // TLB miss, fault (priority over miss), and a silently dropped empty pair.
    drive_in(1, 0, 0, 0, 1, 0, 32'h0000_5000, '0);
    step(); in_valid = 1'b0;
    check_bit("miss_pulse_hi", tlb_miss, 1'b1);
    check_bit("miss_busy", busy, 1'b0);
    step();
    check_bit("miss_pulse_lo", tlb_miss, 1'b0);
    drive_in(1, 0, 0, 1, 1, 1, 32'h0000_6000, 32'h0000_6040);
    step(); in_valid = 1'b0;
    check_bit("fault_hi", fault, 1'b1);
    check_bit("fault_no_miss", tlb_miss, 1'b0);
    drive_in(1, 1, 0, 0, 0, 0, 32'h0000_7000, 32'h0000_7040);
    step(); in_valid = 1'b0;
    check_bit("fault_lo", fault, 1'b0);
    step();
    check_bit("drop_busy", busy, 1'b0);

    // Cached pair; an early even ack while req is low must be ignored.
    drive_in(1, 1, 0, 0, 1, 1, 32'h0000_1000, 32'h0000_1040);
    step(); in_valid = 1'b0; ic_even_ack = 1'b1;
    check_bit("pair_req_not_yet", ic_even_req, 1'b0);
    step(); ic_even_ack = 1'b0;
    check_bit("pair_even_req", ic_even_req, 1'b1);
    check_bit("pair_odd_req", ic_odd_req, 1'b1);
    check("pair_even_addr", ic_even_addr, 32'h0000_1000);
    check("pair_odd_addr", ic_odd_addr, 32'h0000_1040);
    ic_odd_ack = 1'b1;
    step(); ic_odd_ack = 1'b0;
    check_bit("pair_odd_dropped", ic_odd_req, 1'b0);
    check_bit("pair_even_held", ic_even_req, 1'b1);
    step(); ic_even_ack = 1'b1;
    step(); ic_even_ack = 1'b0;
    check_st("pair_pop", state_dbg, ST_POP);
    check_bit("pair_pop_busy", busy, 1'b1);
    step();
    check_bit("pair_idle_busy", busy, 1'b0);

    // MMIO pair, then async reset while the odd half is outstanding.
    drive_in(1, 1, 1, 0, 1, 1, 32'h8000_0000, 32'h8000_0040);
    step(); in_valid = 1'b0;
    step();
    check_bit("mmio_req_e", mmio_req, 1'b1);
    check("mmio_addr_e", mmio_addr, 32'h8000_0000);
    check_bit("mmio_no_ic", ic_even_req | ic_odd_req, 1'b0);
    step(); mmio_ack = 1'b1;
    step(); mmio_ack = 1'b0;
    check_st("mmio_state_o", state_dbg, ST_MMIO_O);
    check("mmio_addr_o", mmio_addr, 32'h8000_0040);
    step();
    #2 rst = 1'b0;
    #1;
    check_bit("arst_mmio_req", mmio_req, 1'b0);
    check("arst_mmio_addr", mmio_addr, '0);
    check_bit("arst_busy", busy, 1'b0);
    check_bit("arst_in_ready", in_ready, 1'b1);
    check_st("arst_state", state_dbg, ST_IDLE);
    @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Full queue: four accepts, fifth held until the head retires (pointer wrap).
    for (int i = 0; i < 4; i++) begin
      drive_in(1, 1, 0, 0, 1, i[0], 32'h0000_2000 + 32'(i) * 32'h80, 32'h0000_2040 + 32'(i) * 32'h80);
      step();
    end
    drive_in(1, 1, 0, 0, 1, 1, 32'h0000_2200, 32'h0000_2240);
    check_bit("full_in_ready", in_ready, 1'b0);
    check_bit("full_head_req", ic_even_req, 1'b1);
    ic_even_ack = 1'b1;
    step(); ic_even_ack = 1'b0;
    check_bit("full_during_pop", in_ready, 1'b0);
    step();
    check_bit("full_after_pop", in_ready, 1'b1);
    step(); in_valid = 1'b0;
    check_bit("full_again", in_ready, 1'b0);
    auto_ack = 1'b1;
    wait_idle(200);
    auto_ack = 1'b0;
    ic_even_ack = 1'b0; ic_odd_ack = 1'b0; mmio_ack = 1'b0;

    // Flush mid-ISSUE with a same-cycle ack and a same-cycle (missing) translation.
    drive_in(1, 1, 0, 0, 1, 1, 32'h0000_3000, 32'h0000_3040);
    step(); in_valid = 1'b0;
    step();
    check_bit("flush_pre_req", ic_even_req, 1'b1);
    flush = 1'b1; ic_even_ack = 1'b1;
    drive_in(1, 0, 0, 0, 1, 0, 32'h0000_3100, '0);
    step(); flush = 1'b0; ic_even_ack = 1'b0; in_valid = 1'b0;
    check_bit("flush_even_req", ic_even_req, 1'b0);
    check_bit("flush_odd_req", ic_odd_req, 1'b0);
    check_bit("flush_busy", busy, 1'b0);
    check_bit("flush_in_ready", in_ready, 1'b1);
    check_st("flush_state", state_dbg, ST_IDLE);
    drive_in(1, 1, 0, 0, 1, 1, 32'h0000_3200, 32'h0000_3240);
    step(); in_valid = 1'b0;
    auto_ack = 1'b1;
    wait_idle(100);

    // Randomized traffic with random acks, back-pressure and occasional flushes.
    for (int c = 0; c < 600; c++) begin
      drive_in($urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom() & 32'hFFFF_FFC0, $urandom() & 32'hFFFF_FFC0);
      flush = ($urandom_range(0, 49) == 0);
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    wait_idle(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/f2_fetch_req.md
Name: f2_fetch_req

Overview:
Fetch-request stage downstream of f1 translation. Accepts the translated even/odd cache-line physical addresses and TLB status from f1 and buffers them in a small in-order queue. Issues each line to the even or odd I-cache bank with a req/ack handshake, or to the uncached MMIO port when pcd is set. Reports TLB misses and exceptions instead of issuing them, and back-pressures f1 when full.

Parameters:
XLEN, 32, physical address width
CLC_WIDTH, 26, cache-line-address width (line offset = XLEN-CLC_WIDTH)
DEPTH, 4, request queue entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  discard all queued/in-flight requests
in_valid  in  1  f1 presents a translation this cycle
in_ready  out  1  queue can accept (= !full)
hit  in  1  TLB hit from f1
pcd  in  1  page-cache-disable (MMIO) from f1
exceptions  in  1  translation fault from f1
addr_even_valid  in  1  even line needed
addr_odd_valid  in  1  odd line needed
addr_even  in  XLEN  even line physical address
addr_odd  in  XLEN  odd line physical address
ic_even_req  out  1  even-bank request
ic_even_addr  out  XLEN  even-bank address
ic_even_ack  in  1  even-bank accept
ic_odd_req  out  1  odd-bank request
ic_odd_addr  out  XLEN  odd-bank address
ic_odd_ack  in  1  odd-bank accept
mmio_req  out  1  uncached request
mmio_addr  out  XLEN  uncached address
mmio_ack  in  1  uncached accept
tlb_miss  out  1  one-cycle miss pulse
fault  out  1  one-cycle exception pulse
busy  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset (rst=0, async): queue empty, pointers/count 0, FSM IDLE; all req outputs 0, all addrs 0, tlb_miss=fault=busy=0, in_ready=1.
- Accept = in_valid && in_ready && !flush. On accept:
  - exceptions=1: no enqueue; fault=1 next cycle (priority over miss).
  - else hit=0: no enqueue; tlb_miss=1 next cycle.
  - else if neither addr_*_valid: dropped silently.
  - else enqueue {addr_even, addr_odd, even_v, odd_v, pcd}.
- in_ready = !full; no same-cycle enqueue-into-full, even when pop occurs that cycle. count width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- Head FSM, states IDLE, ISSUE, MMIO_E, MMIO_O, POP:
  - IDLE: queue non-empty -> ISSUE if !pcd, else MMIO_E if even_v, else MMIO_O. First req is asserted the cycle after the FSM leaves IDLE; minimum enqueue-to-req latency is 2 cycles.
  - ISSUE: ic_even_req=even_v, ic_odd_req=odd_v in parallel, addrs from head. Each req is held with a stable addr until its ack, then deasserts next cycle; per-bank done bits are tracked. Both required banks done -> POP. Acks may arrive in either order or together.
  - MMIO_E: mmio_req with addr_even until mmio_ack; then MMIO_O if odd_v, else POP. MMIO_O: addr_odd until ack -> POP. MMIO lines are strictly sequential, even first.
  - POP: dequeue head, -> IDLE (one bubble per entry).
- Ack while the matching req is low: ignored.
- flush (synchronous): next cycle queue is empty, FSM IDLE, all req=0, done bits cleared. Same-cycle acks and in_valid are ignored. flush outranks every other event.
- busy = (count!=0) || state!=IDLE.

Decomposition:
- Package fetch_pkg: fetch_state_e enum, queue entry struct {even_addr, odd_addr, even_v, odd_v, pcd}, LINE_OFF = XLEN-CLC_WIDTH.
- Sub-module: fetch_req_fifo (parameterised sync FIFO: push/pop/full/empty/count, async active-low reset). FSM and pulse logic stay in top.

Test Plan:
- Cached pair: in_valid, hit=1, pcd=0, even=0x1000 and odd=0x1040 both valid. Both ic reqs rise 2 cycles later. ic_odd_ack at +1, ic_even_ack at +3. Then POP and busy=0 one cycle after POP.
- MMIO: pcd=1, even=0x8000_0000 and odd=0x8000_0040 valid. mmio_req shows 0x8000_0000 until ack, then 0x8000_0040. No ic_* req asserted.
- Miss/fault: hit=0 -> tlb_miss single pulse, queue count stays 0. exceptions=1 with hit=0 -> fault pulse only, no tlb_miss.
- Full: DEPTH=4, acks held low, 5 back-to-back accepts. in_ready=0 after 4th; 5th held by f1. After head completes and POP, in_ready=1 and the 5th is enqueued; order is preserved across pointer wrap.
- Flush mid-ISSUE: ic_even_req high and flush=1 with ic_even_ack=1 in the same cycle. Next cycle all req=0, count=0, busy=0; the ack has no effect.
- Async reset mid-MMIO_O: drop rst low between clock edges. Outputs go to reset values immediately, without a clock edge.
